accel_accumulator: RTL and testbench
====================================

Name: accel_accumulator

Overview:
- Sits directly downstream of the pairwise acceleration pipeline.
- Consumes the pipeline's per-pair (ax, ay) stream, tagged with target-body index, and sums all contributions per body into 64-bit IEEE-754 double accumulators.
- After all n_bodies*n_bodies contributions for a frame arrive, streams the total acceleration per body, in index order, to the integrator stage.
- Input is fixed-latency with no stall; output uses a valid/ready handshake.

Parameters:
- MAX_BODIES, 64, accumulator depth (bodies per frame).
- IDX_W, $clog2(MAX_BODIES), body-index width.
- AddTime, 20, latency in cycles of the FP adder IP.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame
- n_bodies  in  IDX_W+1  bodies this frame (1..MAX_BODIES), latched on start
- in_valid  in  1  contribution present (no back-pressure)
- in_idx  in  IDX_W  target body i of contribution
- in_ax  in  64  x acceleration contribution (double)
- in_ay  in  64  y acceleration contribution (double)
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- out_idx  out  IDX_W  body index of result
- out_ax  out  64  summed x acceleration
- out_ay  out  64  summed y acceleration
- out_last  out  1  marks body n_bodies-1
- busy  out  1  high in any state other than IDLE
- hazard_err  out  1  sticky; cleared on start

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - out_valid, out_last, busy and hazard_err = 0.
  - out_idx, out_ax and out_ay = 0.
  - Adder IP areset is driven by ~rst_n.
- States: IDLE -> ACCUM -> DRAIN -> OUTPUT -> IDLE.
- IDLE:
  - start=1 latches n_bodies, clears the per-body touched bitvector and contribution counter in one cycle, clears hazard_err, then goes to ACCUM.
  - in_valid is ignored.
- start in any non-IDLE state is ignored.
- ACCUM:
  - Each in_valid: read acc[in_idx] in a 1-cycle register stage. Operand is acc[in_idx] if touched, else +0.0.
  - Add in_ax and in_ay via the adder. Write back AddTime+1 cycles after acceptance and set touched[in_idx].
  - Memory read-during-write returns the new data.
  - Contribution counter increments per in_valid. When it reaches n_bodies*n_bodies, go to DRAIN.
  - in_valid after the final count is ignored.
- Hazard: in_valid whose in_idx equals an in-flight index (accepted, not yet written back) sets hazard_err.
  - The sample is still processed; the affected sum is undefined.
  - Upstream issue order (i inner loop) guarantees spacing ≥ AddTime+1 when n_bodies ≥ AddTime+1; otherwise the upstream stage inserts bubbles.
- in_idx ≥ n_bodies: sample dropped, not counted, sets hazard_err.
- DRAIN: wait until the in-flight valid pipeline is empty (≤ AddTime+1 cycles), then go to OUTPUT with read pointer 0.
- OUTPUT:
  - Present acc[ptr] on out_* with out_valid=1. Words from untouched entries are +0.0.
  - Data is held stable while out_valid && !out_ready.
  - On handshake, ptr increments. out_last=1 when ptr==n_bodies-1. The handshake on out_last returns to IDLE, out_valid=0.
  - Registered output, 1-cycle bubble permitted between words.
- Reset asserted mid-frame aborts immediately. Partial sums are discarded; the next start re-clears via touched.
- Self-pair contributions arrive as 0.0 and are summed normally.

Optional Feature:
- Macro: ACC_NAN_CHECK_EN.
- With it: adds output port nan_err (1 bit, sticky, cleared on start and reset). Set when an accepted in_ax or in_ay has exponent all ones (NaN or Inf).
- Without it: port and logic absent; NaN/Inf propagate silently.

Decomposition:
- Shared package nbody_pkg holds:
  - typedef fp64_t (logic [63:0]).
  - state enum acc_state_t.
  - constants ADD_TIME=20, MULT_TIME=11, INVSQRT_TIME=27, FP_ZERO=64'h0.
- Sub-module acc_lane: one axis's accumulator RAM, touched-gated operand mux, AddSub adder, writeback path. Instantiated twice (x, y).
- Tag/valid pipeline and FSM stay in the top block.

Test Plan:
- n_bodies=24, 576 contributions, all in_ax=0x3FF0000000000000 (1.0), in_ay=0xBFE0000000000000 (-0.5), i-inner order -> 24 outputs, each out_ax=0x4038000000000000 (24.0), out_ay=0xC028000000000000 (-12.0); out_last on idx 23; hazard_err=0.
- n_bodies=4, back-to-back same-order stream -> hazard_err=1 by end of frame; FSM still completes with 4 outputs.
- out_ready toggled 1-0-0-1 during OUTPUT -> out_idx and out_ax stable while stalled; no word skipped or duplicated.
- rst_n pulsed low mid-ACCUM -> same cycle: busy=0, out_valid=0. New start with n_bodies=24 and all 2.0 inputs -> outputs 48.0 (0x4048000000000000), no stale residue.
- start pulsed during ACCUM and in_idx=30 with n_bodies=24 -> start ignored; bad sample dropped and uncounted; hazard_err=1.
- ACC_NAN_CHECK_EN defined, one in_ax=0x7FF8000000000000 -> nan_err=1 and stays 1 until next start.

Source files
------------

// File: rtl/nbody_pkg.sv
// Shared types and constants for the n-body acceleration datapath.
//   fp64_t       : raw IEEE-754 binary64 word
//   acc_state_t  : accumulator frame FSM states
//   *_TIME       : latencies of the floating-point IP cores
//   fp64_add     : combinational binary64 add (round-to-nearest-even),
//                  used as the arithmetic core of the pipelined adder
//   fp64_is_special : exponent all ones (NaN or Inf)
package nbody_pkg;

    typedef logic [63:0] fp64_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } acc_state_t;

    localparam int    ADD_TIME     = 20;
    localparam int    MULT_TIME    = 11;
    localparam int    INVSQRT_TIME = 27;
    localparam fp64_t FP_ZERO      = 64'h0;

    function automatic logic fp64_is_special(input fp64_t v);
        return v[62:52] == 11'h7FF;
    endfunction

    function automatic fp64_t fp64_add(input fp64_t a, input fp64_t b);
        fp64_t       x, y, res;
        logic [12:0] ex, ey, e, d;
        logic [55:0] mx, my, ms, mask;
        logic [56:0] sum;
        logic [53:0] mr;
        logic        rnd;
        res  = FP_ZERO;
        x    = a;
        y    = b;
        ex   = '0;
        ey   = '0;
        e    = '0;
        d    = '0;
        mx   = '0;
        my   = '0;
        ms   = '0;
        mask = '0;
        sum  = '0;
        mr   = '0;
        rnd  = 1'b0;
        if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) begin
            if (a[62:52] == 11'h7FF && a[51:0] != 52'd0)
                res = a | 64'h0008_0000_0000_0000;
            else if (b[62:52] == 11'h7FF && b[51:0] != 52'd0)
                res = b | 64'h0008_0000_0000_0000;
            else if (a[62:52] == 11'h7FF && b[62:52] == 11'h7FF && a[63] != b[63])
                res = 64'h7FF8_0000_0000_0000;   // inf - inf
            else if (a[62:52] == 11'h7FF)
                res = a;
            else
                res = b;
        end else begin
            // order by magnitude so the subtraction never borrows
            if (a[62:0] < b[62:0]) begin
                x = b;
                y = a;
            end
            ex = (x[62:52] == 11'd0) ? 13'd1 : {2'b00, x[62:52]};
            ey = (y[62:52] == 11'd0) ? 13'd1 : {2'b00, y[62:52]};
            mx = {x[62:52] != 11'd0, x[51:0], 3'b000};
            my = {y[62:52] != 11'd0, y[51:0], 3'b000};
            d  = ex - ey;
            // align smaller operand, folding shifted-out bits into sticky
            if (d >= 13'd56) begin
                ms = {55'd0, |my};
            end else begin
                mask = (56'd1 << d) - 56'd1;
                ms   = (my >> d) | {55'd0, |(my & mask)};
            end
            e = ex;
            if (x[63] == y[63]) begin
                sum = {1'b0, mx} + {1'b0, ms};
                if (sum[56]) begin
                    sum = {1'b0, sum[56:2], sum[1] | sum[0]};
                    e   = e + 13'd1;
                end
            end else begin
                sum = {1'b0, mx - ms};
            end
            if (sum == 57'd0) begin
                res = {x[63] & y[63], 63'd0};
            end else begin
                // normalise left, stopping at the subnormal boundary
                for (int i = 0; i < 55; i++) begin
                    if (!sum[55] && e > 13'd1) begin
                        sum = sum << 1;
                        e   = e - 13'd1;
                    end
                end
                rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
                mr  = {1'b0, sum[55:3]} + {53'd0, rnd};
                if (mr[53]) begin
                    mr = mr >> 1;
                    e  = e + 13'd1;
                end
                if (e >= 13'h7FF)
                    res = {x[63], 11'h7FF, 52'd0};
                else
                    res = {x[63], mr[52] ? e[10:0] : 11'd0, mr[51:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/accel_accumulator_if.sv
// Contribution stream (in_*) and result stream (out_*) of the accumulator.
//   slave  : accumulator side (consumes in_*, produces out_*)
//   master : upstream/downstream side (drives in_* and out_ready)
interface accel_accumulator_if #(
    parameter int IDX_W = 6
);
    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    logic [63:0]      in_ax;
    logic [63:0]      in_ay;

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [63:0]      out_ax;
    logic [63:0]      out_ay;
    logic             out_last;

    modport slave (
        input  in_valid, in_idx, in_ax, in_ay, out_ready,
        output out_valid, out_idx, out_ax, out_ay, out_last
    );

    modport master (
        output in_valid, in_idx, in_ax, in_ay, out_ready,
        input  out_valid, out_idx, out_ax, out_ay, out_last
    );
endinterface

// File: rtl/acc_lane.sv
// One axis of the per-body accumulator.
//   rd_addr/rd_data : registered RAM read; a same-cycle write to the same
//                     address is forwarded so the newest sum is returned
//   rd_touched      : registered alongside rd_data; untouched entries read as +0.0
//   addend          : contribution, sampled with the read
//   wb_en/wb_addr   : write back the adder result (AddTime cycles after its inputs)
module acc_lane
    import nbody_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int AddTime = ADD_TIME
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_addr,
    output fp64_t            rd_data,
    input  logic             rd_touched,
    input  fp64_t            addend,
    input  logic             wb_en,
    input  logic [IDX_W-1:0] wb_addr
);
    fp64_t                          mem [DEPTH];
    fp64_t                          addend_q;
    fp64_t                          operand;
    fp64_t                          wb_data;
    logic [AddTime-1:0][63:0]       sum_pipe;
    logic                           areset;

    assign areset  = ~rst_n;
    assign wb_data = sum_pipe[AddTime-1];
    assign operand = rd_touched ? rd_data : FP_ZERO;

    always_ff @(posedge clk) begin
        if (wb_en)
            mem[wb_addr] <= wb_data;
        rd_data  <= (wb_en && wb_addr == rd_addr) ? wb_data : mem[rd_addr];
        addend_q <= addend;
    end

    // adder core: combinational add followed by AddTime register stages
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            sum_pipe <= '0;
        else
            sum_pipe <= {sum_pipe[AddTime-2:0], fp64_add(operand, addend_q)};
    end
endmodule

// File: rtl/accel_accumulator.sv
// Per-body acceleration accumulator.
// Sums n_bodies*n_bodies (ax, ay) contributions into per-body double
// accumulators, then streams the totals in index order over a valid/ready
// handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, n_bodies   : frame start pulse and body count (latched on start)
//   bus (slave)       : in_* contribution stream, out_* result stream
//   busy              : FSM not in IDLE
//   hazard_err        : sticky; same-index overlap in the adder or bad index
//   nan_err           : sticky NaN/Inf input flag, present only when
//                       ACC_NAN_CHECK_EN is defined
module accel_accumulator
    import nbody_pkg::*;
#(
    parameter int MAX_BODIES = 64,
    parameter int IDX_W      = $clog2(MAX_BODIES),
    parameter int AddTime    = ADD_TIME
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IDX_W:0]     n_bodies,
    accel_accumulator_if.slave bus,
    output logic               busy,
    output logic               hazard_err
`ifdef ACC_NAN_CHECK_EN
    ,
    output logic               nan_err
`endif
);
    localparam int CNT_W = 2 * (IDX_W + 1);

    acc_state_t                      state, state_next;
    logic [IDX_W:0]                  n_q;
    logic [CNT_W-1:0]                cnt, total;
    logic [MAX_BODIES-1:0]           touched;
    logic [AddTime+1:1]              vld_pipe;
    logic [AddTime+1:1][IDX_W-1:0]   idx_pipe;
    logic [IDX_W-1:0]                ptr, rd_addr, wb_idx;
    logic                            rd_pend, rd_touched;
    logic                            in_range, accept, inflight_hit;
    logic                            wb_en, out_hs, is_last, pipe_empty;
    fp64_t                           rd_ax, rd_ay;

    assign busy       = (state != IDLE);
    assign total      = CNT_W'(n_q) * CNT_W'(n_q);
    assign in_range   = {1'b0, bus.in_idx} < n_q;
    assign accept     = (state == ACCUM) && bus.in_valid && in_range;
    assign wb_en      = vld_pipe[AddTime+1];
    assign wb_idx     = idx_pipe[AddTime+1];
    assign pipe_empty = (vld_pipe == '0);
    assign out_hs     = bus.out_valid && bus.out_ready;
    assign is_last    = ({1'b0, ptr} == n_q - 1'b1);

    // In flight = accepted but not yet at the writeback stage; the
    // writeback stage itself is covered by RAM forwarding.
    always_comb begin
        inflight_hit = 1'b0;
        for (int k = 1; k <= AddTime; k++)
            if (vld_pipe[k] && idx_pipe[k] == bus.in_idx)
                inflight_hit = 1'b1;
    end

    // Single RAM read port: contribution index while accumulating, result
    // pointer (pre-incremented on handshake) while draining results.
    always_comb begin
        rd_addr = '0;
        case (state)
            ACCUM:   rd_addr = bus.in_idx;
            OUTPUT:  rd_addr = out_hs ? ptr + 1'b1 : ptr;
            default: rd_addr = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (accept && cnt + 1'b1 == total) state_next = DRAIN;
            DRAIN:   if (pipe_empty) state_next = OUTPUT;
            OUTPUT:  if (out_hs && bus.out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk)
        idx_pipe <= {idx_pipe[AddTime:1], bus.in_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q           <= '0;
            cnt           <= '0;
            touched       <= '0;
            vld_pipe      <= '0;
            hazard_err    <= 1'b0;
            ptr           <= '0;
            rd_pend       <= 1'b0;
            rd_touched    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_ax    <= FP_ZERO;
            bus.out_ay    <= FP_ZERO;
        end else begin
            vld_pipe   <= {vld_pipe[AddTime:1], accept};
            rd_touched <= touched[rd_addr] | (wb_en && wb_idx == rd_addr);
            if (wb_en)
                touched[wb_idx] <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q        <= n_bodies;
                        cnt        <= '0;
                        touched    <= '0;
                        hazard_err <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept)
                        cnt <= cnt + 1'b1;
                    if (bus.in_valid && (!in_range || inflight_hit))
                        hazard_err <= 1'b1;
                end
                DRAIN: begin
                    // read of entry 0 is issued on this same cycle
                    if (pipe_empty) begin
                        ptr     <= '0;
                        rd_pend <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (rd_pend) begin
                        bus.out_valid <= 1'b1;
                        bus.out_idx   <= ptr;
                        bus.out_ax    <= rd_touched ? rd_ax : FP_ZERO;
                        bus.out_ay    <= rd_touched ? rd_ay : FP_ZERO;
                        bus.out_last  <= is_last;
                        rd_pend       <= 1'b0;
                    end else if (out_hs) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (!bus.out_last) begin
                            ptr     <= ptr + 1'b1;
                            rd_pend <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ACC_NAN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nan_err <= 1'b0;
        else if (state == IDLE && start)
            nan_err <= 1'b0;
        else if (accept && (fp64_is_special(bus.in_ax) || fp64_is_special(bus.in_ay)))
            nan_err <= 1'b1;
    end
`endif

    acc_lane #(.DEPTH(MAX_BODIES), .IDX_W(IDX_W), .AddTime(AddTime)) u_lane_x (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_ax),
        .rd_touched (rd_touched),
        .addend     (bus.in_ax),
        .wb_en      (wb_en),
        .wb_addr    (wb_idx)
    );

    acc_lane #(.DEPTH(MAX_BODIES), .IDX_W(IDX_W), .AddTime(AddTime)) u_lane_y (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_ay),
        .rd_touched (rd_touched),
        .addend     (bus.in_ay),
        .wb_en      (wb_en),
        .wb_addr    (wb_idx)
    );
endmodule

// File: tb/tb_accel_accumulator.sv
// Directed bench for accel_accumulator; expected sums are hand-computed
// binary64 constants. Define ACC_NAN_CHECK_EN to include the nan_err test.
module tb_accel_accumulator;
    localparam int IDX_W = 6;

    localparam logic [63:0] D_ONE   = 64'h3FF0_0000_0000_0000; //  1.0
    localparam logic [63:0] D_MHALF = 64'hBFE0_0000_0000_0000; // -0.5
    localparam logic [63:0] D_TWO   = 64'h4000_0000_0000_0000; //  2.0
    localparam logic [63:0] D_3     = 64'h4008_0000_0000_0000; //  3.0
    localparam logic [63:0] D_M1P5  = 64'hBFF8_0000_0000_0000; // -1.5
    localparam logic [63:0] D_24    = 64'h4038_0000_0000_0000; //  24.0
    localparam logic [63:0] D_M12   = 64'hC028_0000_0000_0000; // -12.0
    localparam logic [63:0] D_48    = 64'h4048_0000_0000_0000; //  48.0
    localparam logic [63:0] D_100   = 64'h4059_0000_0000_0000; //  100.0
    localparam logic [63:0] D_NAN   = 64'h7FF8_0000_0000_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [IDX_W:0] n_bodies = '0;
    logic           busy, hazard_err;
`ifdef ACC_NAN_CHECK_EN
    logic           nan_err;
`endif
    int errors = 0;
    int checks = 0;

    accel_accumulator_if #(.IDX_W(IDX_W)) bus ();

    accel_accumulator #(.MAX_BODIES(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_bodies   (n_bodies),
        .bus        (bus),
        .busy       (busy),
        .hazard_err (hazard_err)
`ifdef ACC_NAN_CHECK_EN
        ,
        .nan_err    (nan_err)
`endif
    );

    always #5 clk = ~clk;

    // all tasks start and end at 1 time unit after a rising edge
    task automatic do_start(input int n);
        n_bodies = n[IDX_W:0];
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [63:0] ax, input logic [63:0] ay,
                              input int gap);
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                bus.in_valid = 1'b1;
                bus.in_idx   = i[IDX_W-1:0];
                bus.in_ax    = ax;
                bus.in_ay    = ay;
                @(posedge clk); #1;
                if (gap > 0) begin
                    bus.in_valid = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b want 0", bus.out_last); end
        checks++; if (hazard_err !== 1'b0) begin errors++; $display("FAIL reset hazard_err: got %b want 0", hazard_err); end
        checks++; if (bus.out_idx !== '0) begin errors++; $display("FAIL reset out_idx: got %0d want 0", bus.out_idx); end
        checks++; if (bus.out_ax !== 64'd0 || bus.out_ay !== 64'd0) begin
            errors++; $display("FAIL reset out_ax/ay: got %h/%h want 0/0", bus.out_ax, bus.out_ay);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame24();
        int got = 0;
        int cyc = 0;
        do_start(24);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame24 busy: got %b want 1", busy); end
        send_frame(24, D_ONE, D_MHALF, 0);
        bus.out_ready = 1'b1;
        while (got < 24 && cyc < 400) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                if (bus.out_idx !== got[IDX_W-1:0] || bus.out_ax !== D_24 || bus.out_ay !== D_M12
                    || bus.out_last !== (got == 23)) begin
                    errors++;
                    $display("FAIL frame24 word %0d: got idx=%0d ax=%h ay=%h last=%b want idx=%0d ax=%h ay=%h last=%b",
                             got, bus.out_idx, bus.out_ax, bus.out_ay, bus.out_last, got, D_24, D_M12, got == 23);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 24) begin errors++; $display("FAIL frame24 count: got %0d want 24", got); end
        checks++; if (hazard_err !== 1'b0) begin errors++; $display("FAIL frame24 hazard_err: got %b want 0", hazard_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame24 end busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int cyc = 0;
        do_start(4);
        send_frame(4, D_ONE, D_MHALF, 0);
        checks++; if (hazard_err !== 1'b1) begin errors++; $display("FAIL b2b hazard_err: got %b want 1", hazard_err); end
        bus.out_ready = 1'b1;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                if (bus.out_idx !== got[IDX_W-1:0] || bus.out_last !== (got == 3)) begin
                    errors++;
                    $display("FAIL b2b word %0d: got idx=%0d last=%b want idx=%0d last=%b",
                             got, bus.out_idx, bus.out_last, got, got == 3);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL b2b count: got %0d want 4", got); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b end busy: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        int          got = 0;
        int          cyc = 0;
        int          stalls = 0;
        logic [3:0]  pat = 4'b1001;  // ready sequence 1,0,0,1
        do_start(3);
        checks++; if (hazard_err !== 1'b0) begin errors++; $display("FAIL stall hazard cleared on start: got %b want 0", hazard_err); end
        send_frame(3, D_ONE, D_MHALF, 22);
        while (got < 3 && cyc < 400) begin
            bus.out_ready = pat[cyc % 4];
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                if (bus.out_idx !== got[IDX_W-1:0] || bus.out_ax !== D_3) begin
                    errors++;
                    $display("FAIL stall word %0d ready=%b: got idx=%0d ax=%h want idx=%0d ax=%h",
                             got, bus.out_ready, bus.out_idx, bus.out_ax, got, D_3);
                end
                if (bus.out_ready) begin
                    checks++;
                    if (bus.out_ay !== D_M1P5 || bus.out_last !== (got == 2)) begin
                        errors++;
                        $display("FAIL stall word %0d: got ay=%h last=%b want ay=%h last=%b",
                                 got, bus.out_ay, bus.out_last, D_M1P5, got == 2);
                    end
                    got++;
                end else begin
                    stalls++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.out_ready = 1'b1;
        checks++; if (got != 3) begin errors++; $display("FAIL stall count: got %0d want 3", got); end
        checks++; if (stalls == 0) begin errors++; $display("FAIL stall stalled cycles: got %0d want >0", stalls); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall end busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        int cyc = 0;
        do_start(24);
        for (int k = 0; k < 100; k++) begin
            bus.in_valid = 1'b1;
            bus.in_idx   = 6'(k % 24);
            bus.in_ax    = D_ONE;
            bus.in_ay    = D_ONE;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid busy/out_valid: got %b/%b want 0/0", busy, bus.out_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(24);
        send_frame(24, D_TWO, D_TWO, 0);
        bus.out_ready = 1'b1;
        while (got < 24 && cyc < 400) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                if (bus.out_idx !== got[IDX_W-1:0] || bus.out_ax !== D_48 || bus.out_ay !== D_48) begin
                    errors++;
                    $display("FAIL reset_mid word %0d: got idx=%0d ax=%h ay=%h want idx=%0d ax=%h ay=%h",
                             got, bus.out_idx, bus.out_ax, bus.out_ay, got, D_48, D_48);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 24) begin errors++; $display("FAIL reset_mid count: got %0d want 24", got); end
    endtask

    task automatic test_bad_idx();
        int got = 0;
        int cyc = 0;
        do_start(24);
        // start while accumulating must not relatch n_bodies
        n_bodies = 7'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bad_idx busy after start: got %b want 1", busy); end
        for (int j = 0; j < 24; j++) begin
            for (int i = 0; i < 24; i++) begin
                bus.in_valid = 1'b1;
                bus.in_idx   = i[IDX_W-1:0];
                bus.in_ax    = D_ONE;
                bus.in_ay    = D_MHALF;
                @(posedge clk); #1;
                if (j == 0 && i == 23) begin
                    bus.in_idx = 6'd30;
                    bus.in_ax  = D_100;
                    bus.in_ay  = D_100;
                    @(posedge clk); #1;
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (hazard_err !== 1'b1) begin errors++; $display("FAIL bad_idx hazard_err: got %b want 1", hazard_err); end
        bus.out_ready = 1'b1;
        while (got < 24 && cyc < 400) begin
            @(negedge clk);
            if (bus.out_valid) begin
                checks++;
                if (bus.out_idx !== got[IDX_W-1:0] || bus.out_ax !== D_24 || bus.out_ay !== D_M12
                    || bus.out_last !== (got == 23)) begin
                    errors++;
                    $display("FAIL bad_idx word %0d: got idx=%0d ax=%h ay=%h last=%b want idx=%0d ax=%h ay=%h last=%b",
                             got, bus.out_idx, bus.out_ax, bus.out_ay, bus.out_last, got, D_24, D_M12, got == 23);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 24) begin errors++; $display("FAIL bad_idx count: got %0d want 24", got); end
    endtask

`ifdef ACC_NAN_CHECK_EN
    task automatic test_nan();
        int got = 0;
        int cyc = 0;
        do_start(1);
        checks++; if (nan_err !== 1'b0) begin errors++; $display("FAIL nan initial: got %b want 0", nan_err); end
        send_frame(1, D_NAN, D_ONE, 0);
        checks++; if (nan_err !== 1'b1) begin errors++; $display("FAIL nan set: got %b want 1", nan_err); end
        bus.out_ready = 1'b1;
        while (got < 1 && cyc < 100) begin
            @(negedge clk);
            if (bus.out_valid) got++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (got != 1 || nan_err !== 1'b1) begin
            errors++; $display("FAIL nan sticky: got words=%0d nan_err=%b want 1/1", got, nan_err);
        end
        do_start(1);
        checks++; if (nan_err !== 1'b0) begin errors++; $display("FAIL nan clear on start: got %b want 0", nan_err); end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.in_ax     = '0;
        bus.in_ay     = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_frame24();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_bad_idx();
`ifdef ACC_NAN_CHECK_EN
        test_nan();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
